// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: PC block, instruction memory, hazard/decode controls and IF/ID outputs.
// Signal names match the surrounding pipeline so the fetch stage drops in unchanged.
interface fetch_unit_if;
  logic [31:0] pcaddr;
  logic [31:0] nxt_pc;
  logic        pc_en;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        flush;
  logic        halt;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_npc;
  logic [31:0] fetch_cnt;

  modport slave (
    input  pcaddr, nxt_pc, ihit, imemload, stall, flush, halt,
    output pc_en, imemREN, imemaddr,
    output ifid_valid, ifid_instr, ifid_pc, ifid_npc, fetch_cnt
  );

  modport master (
    output pcaddr, nxt_pc, ihit, imemload, stall, flush, halt,
    input  pc_en, imemREN, imemaddr,
    input  ifid_valid, ifid_instr, ifid_pc, ifid_npc, fetch_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// Pipeline fetch stage: one instruction in flight, a one-entry skid buffer for
// stalls, IF/ID register, and a delivered-instruction counter.
//
// state  | meaning
// FETCH  | read issued each cycle; ihit delivers into IF/ID or the skid buffer
// HOLD   | skid buffer full; no read issued until stall drops
// HALTED | decode saw HALT; fetch stopped until reset
module fetch_unit #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic CLK,
  input logic RST,
  fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic        ifid_valid_q;
  logic [31:0] ifid_instr_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_npc_q;
  logic [31:0] fetch_cnt_q;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic [31:0] skid_npc;

  assign bus.imemaddr   = bus.pcaddr;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_npc   = ifid_npc_q;
  assign bus.fetch_cnt  = fetch_cnt_q;

  // pc_en fires on acceptance of a hit or on a flush redirect; halt suppresses it.
  always_comb begin
    bus.imemREN = 1'b0;
    bus.pc_en   = 1'b0;
    if (!RST) begin
      bus.imemREN = (state == FETCH);
      if (state != HALTED) begin
        if (bus.flush)
          bus.pc_en = 1'b1;
        else if (!bus.halt && state == FETCH && bus.ihit)
          bus.pc_en = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= FETCH;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= 32'h0;
      ifid_npc_q   <= 32'h0;
      fetch_cnt_q  <= 32'h0;
      skid_valid   <= 1'b0;
      skid_instr   <= NOP_INSTR;
      skid_pc      <= 32'h0;
      skid_npc     <= 32'h0;
    end else begin
      case (state)
        FETCH, HOLD: begin
          if (bus.flush || bus.halt) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 32'h0;
            ifid_npc_q   <= 32'h0;
            skid_valid   <= 1'b0;
            state        <= bus.flush ? FETCH : HALTED;
          end else if (state == FETCH) begin
            if (bus.ihit) begin
              if (bus.stall) begin
                skid_valid <= 1'b1;
                skid_instr <= bus.imemload;
                skid_pc    <= bus.pcaddr;
                skid_npc   <= bus.nxt_pc;
                state      <= HOLD;
              end else begin
                ifid_valid_q <= 1'b1;
                ifid_instr_q <= bus.imemload;
                ifid_pc_q    <= bus.pcaddr;
                ifid_npc_q   <= bus.nxt_pc;
                fetch_cnt_q  <= fetch_cnt_q + 32'd1;
              end
            end
          end else if (!bus.stall) begin
            // Drain the skid entry into IF/ID and resume fetching.
            ifid_valid_q <= skid_valid;
            ifid_instr_q <= skid_instr;
            ifid_pc_q    <= skid_pc;
            ifid_npc_q   <= skid_npc;
            if (skid_valid)
              fetch_cnt_q <= fetch_cnt_q + 32'd1;
            skid_valid   <= 1'b0;
            state        <= FETCH;
          end
        end
        default: begin
          state <= HALTED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with a scoreboard of
// expected IF/ID deliveries compared as the stage produces them.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0040;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_pushed = 0;
  int   n_popped = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
  } ifid_t;
  ifid_t sb_q[$];

  fetch_unit_if bus();

  fetch_unit #(.NOP_INSTR(NOP)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic hit, input logic [31:0] load,
                       input logic stl, input logic fl, input logic hl);
    bus.pcaddr   = pc;
    bus.nxt_pc   = pc + 32'd4;
    bus.ihit     = hit;
    bus.imemload = load;
    bus.stall    = stl;
    bus.flush    = fl;
    bus.halt     = hl;
    #1;
  endtask

  task automatic expect_delivery(input logic [31:0] instr, input logic [31:0] pc);
    ifid_t e;
    e.instr = instr;
    e.pc    = pc;
    e.npc   = pc + 32'd4;
    sb_q.push_back(e);
    n_pushed++;
  endtask

  // Scoreboard monitor: each new valid IF/ID content is one delivery.
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc = 32'h0;
  logic [31:0] prev_instr = 32'h0;
  always @(negedge CLK) begin
    if (bus.ifid_valid && (!prev_valid || bus.ifid_pc != prev_pc || bus.ifid_instr != prev_instr)) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected_delivery", 32'(sb_q.size()), 32'd1);
      end else begin
        ifid_t e;
        e = sb_q.pop_front();
        n_popped++;
        check_val("sb_instr", bus.ifid_instr, e.instr);
        check_val("sb_pc", bus.ifid_pc, e.pc);
        check_val("sb_npc", bus.ifid_npc, e.npc);
      end
    end
    prev_valid = bus.ifid_valid;
    prev_pc    = bus.ifid_pc;
    prev_instr = bus.ifid_instr;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
    check_val("rst_imemren", {31'h0, bus.imemREN}, 32'd0);
    check_val("rst_pc_en", {31'h0, bus.pc_en}, 32'd0);
    cycle();
    cycle();
    check_val("rst_valid", {31'h0, bus.ifid_valid}, 32'd0);
    check_val("rst_instr", bus.ifid_instr, NOP);
    check_val("rst_pc", bus.ifid_pc, 32'h0);
    check_val("rst_npc", bus.ifid_npc, 32'h0);
    check_val("rst_cnt", bus.fetch_cnt, 32'h0);

    RST = 1'b0;
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_val("post_rst_imemren", {31'h0, bus.imemREN}, 32'd1);

    // Straight-line fetch
    drive(32'h0, 1'b1, 32'h2001_0001, 1'b0, 1'b0, 1'b0);
    check_val("sl0_pc_en", {31'h0, bus.pc_en}, 32'd1);
    check_val("sl0_imemaddr", bus.imemaddr, 32'h0);
    expect_delivery(32'h2001_0001, 32'h0);
    cycle();
    drive(32'h4, 1'b1, 32'h2002_0002, 1'b0, 1'b0, 1'b0);
    check_val("sl1_pc_en", {31'h0, bus.pc_en}, 32'd1);
    check_val("sl1_imemaddr", bus.imemaddr, 32'h4);
    expect_delivery(32'h2002_0002, 32'h4);
    cycle();
    check_val("sl_cnt", bus.fetch_cnt, 32'd2);

    // Miss latency: three misses then a hit
    for (int i = 0; i < 3; i++) begin
      drive(32'h8, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      check_val("miss_imemren", {31'h0, bus.imemREN}, 32'd1);
      check_val("miss_pc_en", {31'h0, bus.pc_en}, 32'd0);
      cycle();
      check_val("miss_ifid_hold", bus.ifid_instr, 32'h2002_0002);
    end
    drive(32'h8, 1'b1, 32'h8C22_0000, 1'b0, 1'b0, 1'b0);
    check_val("hit_imemren", {31'h0, bus.imemREN}, 32'd1);
    check_val("hit_pc_en", {31'h0, bus.pc_en}, 32'd1);
    expect_delivery(32'h8C22_0000, 32'h8);
    cycle();
    check_val("miss_instr", bus.ifid_instr, 32'h8C22_0000);
    check_val("miss_cnt", bus.fetch_cnt, 32'd3);

    // Stall into skid buffer, hold two cycles, release
    drive(32'hC, 1'b1, 32'h0022_1820, 1'b1, 1'b0, 1'b0);
    check_val("skid_pc_en", {31'h0, bus.pc_en}, 32'd1);
    cycle();
    for (int i = 0; i < 2; i++) begin
      drive(32'h10, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
      check_val("hold_imemren", {31'h0, bus.imemREN}, 32'd0);
      check_val("hold_pc_en", {31'h0, bus.pc_en}, 32'd0);
      check_val("hold_instr", bus.ifid_instr, 32'h8C22_0000);
      cycle();
    end
    drive(32'h10, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    check_val("drain_pc_en", {31'h0, bus.pc_en}, 32'd0);
    expect_delivery(32'h0022_1820, 32'hC);
    cycle();
    check_val("drain_instr", bus.ifid_instr, 32'h0022_1820);
    check_val("drain_cnt", bus.fetch_cnt, 32'd4);
    drive(32'h10, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_val("drain_fetch", {31'h0, bus.imemREN}, 32'd1);

    // Flush over stall while in HOLD
    drive(32'h10, 1'b1, 32'hAAAA_0001, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(32'h10, 1'b1, 32'hBBBB_0002, 1'b1, 1'b1, 1'b0);
    check_val("flush_pc_en", {31'h0, bus.pc_en}, 32'd1);
    cycle();
    check_val("flush_valid", {31'h0, bus.ifid_valid}, 32'd0);
    check_val("flush_instr", bus.ifid_instr, NOP);
    check_val("flush_pc", bus.ifid_pc, 32'h0);
    check_val("flush_cnt", bus.fetch_cnt, 32'd4);
    drive(32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_val("flush_refetch", {31'h0, bus.imemREN}, 32'd1);
    cycle();
    check_val("flush_buf_dropped", {31'h0, bus.ifid_valid}, 32'd0);

    // Flush during a hit discards the returned word
    drive(32'h40, 1'b1, 32'hCCCC_0003, 1'b0, 1'b1, 1'b0);
    check_val("flush_hit_pc_en", {31'h0, bus.pc_en}, 32'd1);
    cycle();
    check_val("flush_hit_valid", {31'h0, bus.ifid_valid}, 32'd0);
    check_val("flush_hit_cnt", bus.fetch_cnt, 32'd4);
    drive(32'h80, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    expect_delivery(32'h1111_1111, 32'h80);
    cycle();
    check_val("post_flush_cnt", bus.fetch_cnt, 32'd5);

    // Halt, then HALTED ignores everything until reset
    drive(32'h84, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b1);
    check_val("halt_pc_en", {31'h0, bus.pc_en}, 32'd0);
    cycle();
    check_val("halt_valid", {31'h0, bus.ifid_valid}, 32'd0);
    check_val("halt_instr", bus.ifid_instr, NOP);
    for (int i = 0; i < 2; i++) begin
      drive(32'h88, 1'b1, 32'h3333_3333, 1'b0, 1'b1, 1'b0);
      check_val("halted_imemren", {31'h0, bus.imemREN}, 32'd0);
      check_val("halted_pc_en", {31'h0, bus.pc_en}, 32'd0);
      cycle();
      check_val("halted_valid", {31'h0, bus.ifid_valid}, 32'd0);
      check_val("halted_cnt", bus.fetch_cnt, 32'd5);
    end
    RST = 1'b1;
    drive(32'h88, 1'b1, 32'h3333_3333, 1'b0, 1'b0, 1'b0);
    check_val("rst2_pc_en", {31'h0, bus.pc_en}, 32'd0);
    cycle();
    check_val("rst2_valid", {31'h0, bus.ifid_valid}, 32'd0);
    check_val("rst2_instr", bus.ifid_instr, NOP);
    check_val("rst2_npc", bus.ifid_npc, 32'h0);
    check_val("rst2_cnt", bus.fetch_cnt, 32'h0);
    RST = 1'b0;
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_val("rst2_imemren", {31'h0, bus.imemREN}, 32'd1);

    // Counter wrap after backdoor preload
    dut.fetch_cnt_q <= 32'hFFFF_FFFF;
    #1;
    drive(32'h100, 1'b1, 32'h4444_4444, 1'b0, 1'b0, 1'b0);
    expect_delivery(32'h4444_4444, 32'h100);
    cycle();
    check_val("wrap_cnt", bus.fetch_cnt, 32'h0);

    drive(32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    check_val("sb_left", 32'(sb_q.size()), 32'd0);
    check_val("sb_popped", 32'(n_popped), 32'(n_pushed));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
